// File: rtl/sequence_playback_scheduler_pkg.sv
// Shared definitions for the sequence playback scheduler: sizes, state
// encoding and the speed-to-flash-window rule.
package sequence_playback_scheduler_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned ADDR_W  = $clog2(MAX_LEN);
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_FLASH,
    ST_GAP,
    ST_DONE
  } state_t;

  // Slowest speed (0) gives the longest window: four flash units.
  function automatic int unsigned flash_window(input int unsigned flash_unit,
                                               input logic [1:0]  spd);
    return flash_unit * (32'd4 - 32'(spd));
  endfunction

endpackage

// File: rtl/sequence_playback_scheduler_if.sv
// Bundle of controller, timebase, sequence RAM and display signals around the
// playback scheduler. The scheduler uses the slave modport.
interface sequence_playback_scheduler_if;
  import sequence_playback_scheduler_pkg::*;

  logic               start;
  logic               abort;
  logic [LEN_W-1:0]   seqLength;
  logic [1:0]         speedSel;
  logic               tick;
  logic [ADDR_W-1:0]  ramAddr;
  logic               ramReadEn;
  logic [DIGIT_W-1:0] ramData;
  logic [DIGIT_W-1:0] numToFlash;
  logic               noNumToFlash;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, seqLength, speedSel, tick, ramData,
    input  ramAddr, ramReadEn, numToFlash, noNumToFlash, busy, done
  );

  modport slave (
    input  start, abort, seqLength, speedSel, tick, ramData,
    output ramAddr, ramReadEn, numToFlash, noNumToFlash, busy, done
  );

endinterface

// File: rtl/sequence_playback_scheduler_tick_window_counter.sv
// Counts timebase ticks inside a window and flags the tick that reaches the
// target. Shared by the flash and gap windows.
module sequence_playback_scheduler_tick_window_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  input  logic [CNT_W-1:0] target,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = enable && tick && ((count + CNT_W'(1)) == target);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable && tick && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sequence_playback_scheduler.sv
// Plays the stored digit sequence for one round: fetch each digit, show it for
// a speed-dependent number of ticks, blank for a fixed gap, then pulse done.
module sequence_playback_scheduler
  import sequence_playback_scheduler_pkg::*;
#(
  parameter int unsigned FLASH_UNIT = 4,
  parameter int unsigned GAP_TICKS  = 2
) (
  input logic                          clk,
  input logic                          rst,
  sequence_playback_scheduler_if.slave bus
);

  localparam int unsigned CNT_MAX = (4 * FLASH_UNIT > GAP_TICKS) ? 4 * FLASH_UNIT : GAP_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  index;
  logic [LEN_W-1:0]   len;
  logic [1:0]         spd;
  logic [DIGIT_W-1:0] num_q;
  logic               blank_q;
  logic               busy_q;
  logic               done_q;

  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   target;
  logic               accept;
  logic               abort_run;
  logic               last_digit;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               expire;

  assign len_clamped = (bus.seqLength > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.seqLength;
  assign accept      = (state == ST_IDLE) && bus.start && !bus.abort;
  assign abort_run   = (state != ST_IDLE) && bus.abort;
  // len is 6 bits so a full 32-digit sequence ends at index 31.
  assign last_digit  = ({1'b0, index} == (len - LEN_W'(1)));
  assign target      = (state == ST_GAP) ? CNT_W'(GAP_TICKS)
                                         : CNT_W'(flash_window(FLASH_UNIT, spd));

  sequence_playback_scheduler_tick_window_counter #(
    .CNT_W (CNT_W)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .tick   (bus.tick),
    .target (target),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_next = (len_clamped == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        cnt_clear  = 1'b1;
        state_next = ST_FLASH;
      end
      ST_FLASH: begin
        cnt_enable = 1'b1;
        if (expire) state_next = ST_GAP;
      end
      ST_GAP: begin
        cnt_enable = 1'b1;
        if (expire) state_next = last_digit ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort_run) begin
      state_next = ST_IDLE;
      cnt_clear  = 1'b1;
      cnt_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      index   <= '0;
      len     <= '0;
      spd     <= '0;
      num_q   <= '0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_run) begin
        index   <= '0;
        blank_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            len    <= len_clamped;
            spd    <= bus.speedSel;
            index  <= '0;
            busy_q <= 1'b1;
          end
          ST_LOAD: begin
            num_q   <= bus.ramData;
            blank_q <= 1'b0;
          end
          ST_FLASH: if (expire) blank_q <= 1'b1;
          ST_GAP:   if (expire && !last_digit) index <= index + ADDR_W'(1);
          ST_DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ramAddr      = index;
  assign bus.ramReadEn    = (state == ST_FETCH);
  assign bus.numToFlash   = num_q;
  assign bus.noNumToFlash = blank_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
